// File: rtl/peripheral_apb4_initiator.sv
// APB4-Lite initiator: turns one valid/ready command into a single APB transfer and a valid/ready response.
// Optional wait-state timeout is enabled by defining PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN.
module peripheral_apb4_initiator #(
  parameter int PADDR_SIZE     = 4,
  parameter int PDATA_SIZE     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [PADDR_SIZE-1:0]   req_addr,
  input  logic [PDATA_SIZE-1:0]   req_wdata,
  input  logic [PDATA_SIZE/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_SIZE = PDATA_SIZE / 8;

  if ((PDATA_SIZE % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("peripheral_apb4_initiator: PDATA_SIZE must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e                  state_q,     state_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic [PADDR_SIZE-1:0]   paddr_q,     paddr_d;
  logic                    pwrite_q,    pwrite_d;
  logic [PDATA_SIZE-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_SIZE-1:0]    pstrb_q,     pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [PDATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;

`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // The only unregistered output: it must drop the moment reset is asserted.
  assign req_ready = (state_q == ST_IDLE) && PRESETn;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = req_addr;
          pwrite_d  = req_write;
          // Reads must present zero strobes; data is zeroed too to keep the bus quiet.
          pwdata_d  = req_write ? req_wdata : '0;
          pstrb_d   = req_write ? req_strb  : '0;
        end
      end

      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (PREADY) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
        end
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
        // This is the TIMEOUT_CYCLES-th wait state with PREADY still low: abort.
        else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ST_RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Synchronous reset also aborts an in-flight transfer and drops any pending response.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      // NOTE: sequential state is written only with non-blocking assignments.
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef PERIPHERAL_APB4_INITIATOR_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
